// File: rtl/msx_slot_responder_if.sv
// msx_slot_responder_if: MSX slot bus plus backing-memory request/acknowledge port
// Signals:
//   maddr, mdata_in                      MSX address and sampled data bus
//   msltsl, mmreq, miorq, mrd, mwr, mm1  MSX strobes, active-low, asynchronous to clk
//   mdata_out, mdata_oe                  data driven to the MSX bus and its pad enable
//   mwait, mbusdir                       active-low /WAIT and BUSDIR
//   mem_req, mem_we, mem_addr, mem_wdata backing-memory request, held until mem_ack
//   mem_rdata, mem_ack                   backing-memory read data and one-cycle acknowledge
//   timeout                              sticky access-timeout flag
// Modports: slave (the responder), master (the host side / memory model)
interface msx_slot_responder_if;
    logic [15:0] maddr;
    logic [7:0]  mdata_in;
    logic [7:0]  mdata_out;
    logic        mdata_oe;
    logic        msltsl;
    logic        mmreq;
    logic        miorq;
    logic        mrd;
    logic        mwr;
    logic        mm1;
    logic        mwait;
    logic        mbusdir;
    logic        mem_req;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        timeout;

    modport slave (
        input  maddr, mdata_in, msltsl, mmreq, miorq, mrd, mwr, mm1, mem_rdata, mem_ack,
        output mdata_out, mdata_oe, mwait, mbusdir, mem_req, mem_we, mem_addr, mem_wdata, timeout
    );

    modport master (
        output maddr, mdata_in, msltsl, mmreq, miorq, mrd, mwr, mm1, mem_rdata, mem_ack,
        input  mdata_out, mdata_oe, mwait, mbusdir, mem_req, mem_we, mem_addr, mem_wdata, timeout
    );
endinterface

// File: rtl/msx_slot_responder.sv
// msx_slot_responder: MSX cartridge responder with a four-bank 8 KB mapper onto a req/ack memory port
// Ports:
//   clk     system clock, at least 8x the MSX clock
//   mreset  synchronous active-low reset
//   bus     msx_slot_responder_if.slave: MSX bus in/out, backing-memory port, sticky timeout
// Parameters:
//   WAIT_TIMEOUT  clk cycles spent in a request before /WAIT is released and the access abandoned
//   IO_PORT       I/O port address (only with MSX_IO_PORT_EN)
// Build option: define MSX_IO_PORT_EN to add an 8-bit I/O register at IO_PORT
module msx_slot_responder #(
    parameter int WAIT_TIMEOUT = 63
`ifdef MSX_IO_PORT_EN
    ,
    parameter logic [7:0] IO_PORT = 8'h40
`endif
) (
    input logic clk,
    input logic mreset,
    msx_slot_responder_if.slave bus
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DECODE, REQ, DRIVE, REGWR, RELEASE} state_t;

    state_t          r_state;
    logic [3:0]      r_stb1, r_stb2;
    logic [15:0]     r_addr1, r_addr2;
    logic [7:0]      r_din1, r_din2;
    logic            r_armed;
    logic [15:0]     r_addr;
    logic [7:0]      r_wdata;
    logic            r_we;
    logic            r_io;
    logic [3:0][7:0] r_bank;
    logic [CW-1:0]   r_cnt;
    logic            r_to;
    logic            r_ab;
    logic [7:0]      r_dout;
    logic            r_oe;
    logic            r_wait;
    logic            r_req;
    logic            r_mwe;
    logic [20:0]     r_maddr;
    logic [7:0]      r_mwd;
    logic            r_timeout;

    logic       w_sltsl, w_mreq, w_rd, w_wr;
    logic       w_rel, w_mem_start, w_io_start, w_ab;
    logic [2:0] w_bsel;

    // Strobes synchronize to the inactive level so nothing starts out of reset.
    always_ff @(posedge clk) begin
        if (!mreset) begin
            r_stb1  <= '1;
            r_stb2  <= '1;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_din1  <= '0;
            r_din2  <= '0;
        end else begin
            r_stb1  <= {bus.msltsl, bus.mmreq, bus.mrd, bus.mwr};
            r_stb2  <= r_stb1;
            r_addr1 <= bus.maddr;
            r_addr2 <= r_addr1;
            r_din1  <= bus.mdata_in;
            r_din2  <= r_din1;
        end
    end

    assign {w_sltsl, w_mreq, w_rd, w_wr} = r_stb2;
    assign w_mem_start = !w_sltsl && !w_mreq && (w_rd ^ w_wr);
    // An abort seen this cycle counts as well as one latched earlier.
    assign w_ab = r_ab || w_sltsl;
    // Offsetting by two maps windows 2..5 onto 0..3; everything else lands on 4..7.
    assign w_bsel = r_addr[15:13] - 3'd2;

`ifdef MSX_IO_PORT_EN
    logic [1:0] r_iom1, r_iom2;
    logic [7:0] r_io_reg;
    logic       r_busdir;

    always_ff @(posedge clk) begin
        if (!mreset) begin
            r_iom1 <= '1;
            r_iom2 <= '1;
        end else begin
            r_iom1 <= {bus.miorq, bus.mm1};
            r_iom2 <= r_iom1;
        end
    end

    assign w_rel = (&r_stb2) && r_iom2[1];
    // mm1 low with miorq low is an interrupt acknowledge, not a port access.
    assign w_io_start = !r_iom2[1] && r_iom2[0] && (r_addr2[7:0] == IO_PORT) && (w_rd ^ w_wr);
    assign bus.mbusdir = r_busdir;
`else
    assign w_rel = &r_stb2;
    assign w_io_start = 1'b0;
    assign bus.mbusdir = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!mreset) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_io      <= 1'b0;
            r_bank    <= '0;
            r_cnt     <= '0;
            r_to      <= 1'b0;
            r_ab      <= 1'b0;
            r_dout    <= 8'hFF;
            r_oe      <= 1'b0;
            r_wait    <= 1'b1;
            r_req     <= 1'b0;
            r_mwe     <= 1'b0;
            r_maddr   <= '0;
            r_mwd     <= '0;
            r_timeout <= 1'b0;
`ifdef MSX_IO_PORT_EN
            r_io_reg  <= 8'h00;
            r_busdir  <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rel) r_armed <= 1'b1;
                    // A cycle only counts once a full release has been seen since the last one.
                    if (r_armed && (w_mem_start || w_io_start)) begin
                        r_state <= DECODE;
                        r_armed <= 1'b0;
                        r_addr  <= r_addr2;
                        r_wdata <= r_din2;
                        r_we    <= !w_wr;
                        r_io    <= !w_mem_start;
                    end
                end
                DECODE: begin
                    r_cnt <= '0;
                    r_to  <= 1'b0;
                    r_ab  <= 1'b0;
                    if (r_io) begin
`ifdef MSX_IO_PORT_EN
                        if (r_we) begin
                            r_io_reg <= r_wdata;
                            r_state  <= RELEASE;
                        end else begin
                            r_dout   <= r_io_reg;
                            r_oe     <= 1'b1;
                            r_busdir <= 1'b0;
                            r_state  <= DRIVE;
                        end
`else
                        r_state <= RELEASE;
`endif
                    end else if (w_bsel[2]) begin
                        r_state <= RELEASE;
                    end else if (r_we && r_addr[15:13] == 3'd3) begin
                        r_state <= REGWR;
                    end else begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_mwe   <= r_we;
                        r_maddr <= {r_bank[w_bsel[1:0]], r_addr[12:0]};
                        r_mwd   <= r_wdata;
                        r_wait  <= 1'b0;
                    end
                end
                REQ: begin
                    r_ab <= w_ab;
                    if (bus.mem_ack) begin
                        r_req  <= 1'b0;
                        r_wait <= 1'b1;
                        if (!r_mwe && !r_to && !w_ab) begin
                            r_dout  <= bus.mem_rdata;
                            r_oe    <= 1'b1;
                            r_state <= DRIVE;
                        end else if (!r_mwe && r_to && !w_ab && !w_rd) begin
                            // Late ack after a timeout: keep 8'hFF on the bus until mrd rises.
                            r_oe    <= 1'b1;
                            r_state <= DRIVE;
                        end else begin
                            r_oe    <= 1'b0;
                            r_state <= RELEASE;
                        end
                    end else if (w_ab) begin
                        r_wait <= 1'b1;
                        r_oe   <= 1'b0;
                    end else if (r_to) begin
                        r_oe <= !r_mwe && !w_rd;
                    end else if (r_cnt == CW'(WAIT_TIMEOUT - 1)) begin
                        r_to      <= 1'b1;
                        r_timeout <= 1'b1;
                        r_wait    <= 1'b1;
                        r_dout    <= 8'hFF;
                        r_oe      <= !r_mwe;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_rd) begin
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
`ifdef MSX_IO_PORT_EN
                        r_busdir <= 1'b1;
`endif
                    end
                end
                REGWR: begin
                    r_bank[r_addr[12:11]] <= r_wdata;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    if (w_rel) begin
                        r_armed <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mdata_out = r_dout;
    assign bus.mdata_oe  = r_oe;
    assign bus.mwait     = r_wait;
    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_mwe;
    assign bus.mem_addr  = r_maddr;
    assign bus.mem_wdata = r_mwd;
    assign bus.timeout   = r_timeout;
endmodule

// File: doc/msx_slot_responder.md
# msx_slot_responder

Cartridge-side responder for the MSX slot bus: the device end of the bus cycles our host bridge initiates. It decodes slot-selected memory cycles in 0x4000–0xBFFF, translates them through a four-bank 8 KB ASCII8-style mapper onto a request/acknowledge backing-memory port, and holds the Z80 with /WAIT until data returns. All MSX inputs are treated as asynchronous and synchronized to `clk`, which must run at least 8× the MSX clock (nominal 50 MHz vs 3.58 MHz).

## Interface
- `WAIT_TIMEOUT`, 63: maximum `clk` cycles spent waiting for `mem_ack` before the access is abandoned.
- `IO_PORT`, 8'h40: I/O port address; used only with `MSX_IO_PORT_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `mreset`  in  1  synchronous, active-low reset.
- `maddr`  in  16  MSX address bus.
- `mdata_in`  in  8  MSX data bus, as sampled.
- `mdata_out`  out  8  data driven to the MSX bus.
- `mdata_oe`  out  1  high: the pad drives `mdata_out`.
- `msltsl`, `mmreq`, `miorq`, `mrd`, `mwr`, `mm1`  in  1 each  MSX strobes, active-low.
- `mwait`  out  1  active-low /WAIT.
- `mbusdir`  out  1  active-low BUSDIR; asserted only for I/O reads.
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  21  {bank[7:0], maddr[12:0]}.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data; valid when `mem_ack` is high.
- `mem_ack`  in  1  one-cycle acknowledge.
- `timeout`  out  1  sticky; set when an access times out.

## Operation
- Synchronizers: every MSX input passes through a 2-FF synchronizer. `maddr` and `mdata_in` are captured when the FSM leaves IDLE.
- Memory cycle start: synchronized `msltsl`=0 and `mmreq`=0, with exactly one of `mrd` and `mwr` at 0. Both low at once: no cycle is started.
- Bank select: `maddr[15:13]` 2,3,4,5 select bank registers 0..3. Any other value: the cycle is ignored, with no drive and no wait.
- Bank registers, written with no backing access:
  - write to 0x6000–0x67FF sets bank0
  - 0x6800–0x6FFF sets bank1
  - 0x7000–0x77FF sets bank2
  - 0x7800–0x7FFF sets bank3
- Other writes in the window: forwarded to backing memory with `mem_we`=1.
- FSM states:
  - IDLE → DECODE on cycle start.
  - DECODE → REGWR for a bank write; → REQ for a backing access; → RELEASE for an ignored cycle.
  - REQ: `mem_req`=1 and `mwait`=0 until `mem_ack`. On read ack, latch `mem_rdata` and go to DRIVE. On write ack, go to RELEASE.
  - DRIVE: `mdata_oe`=1 and `mwait`=1 while synchronized `mrd`=0; → IDLE when `mrd` rises.
  - REGWR: update the register, then → RELEASE.
  - RELEASE: wait until all strobes are high, then → IDLE.
- Request handshake: `mem_req` stays high until `mem_ack`, even if the MSX aborts. `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high.
- Timeout: a counter runs in REQ. When it reaches `WAIT_TIMEOUT`:
  - release `mwait`
  - set `timeout`
  - a read drives 8'hFF
  - `mem_req` remains high until ack, and the late ack is discarded.
- Abort: if `msltsl` rises during REQ, the FSM finishes the handshake silently and does not drive data.
- Reset values:
  - `mdata_out`=8'hFF, `mdata_oe`=0, `mwait`=1, `mbusdir`=1
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `timeout`=0
  - all banks 0, FSM in IDLE
- Reset mid-operation: reset wins immediately and any outstanding request is dropped.

## Timing
- `mwait` falls 4 `clk` cycles after the strobe falls: 2 synchronizer cycles, then IDLE→DECODE, then DECODE→REQ.
- Read data appears on the bus 1 cycle after `mem_ack`, and `mwait` rises in that same cycle.
- `mdata_oe` falls no later than 3 `clk` cycles after `mrd` rises.
- Bank register writes take effect for the next cycle, with a minimum turnaround of 1 `clk`.
- Back-to-back cycles: a new cycle is only detected after a full strobe release has been seen in IDLE or RELEASE.

## Configuration
- `MSX_IO_PORT_EN` defined:
  - qualifying cycles: `miorq`=0, `mm1`=1, `maddr[7:0]`==`IO_PORT`, independent of `msltsl`.
  - write: stores `mdata_in` in an 8-bit `io_reg` (reset 8'h00).
  - read: drives `io_reg` with `mdata_oe`=1 and `mbusdir`=0 until `mrd` rises.
  - no wait states.
  - `miorq`=0 with `mm1`=0 (interrupt acknowledge) is ignored.
- `MSX_IO_PORT_EN` undefined: `miorq` is ignored, `mbusdir` is held at 1, and no `io_reg` is built.

## Test plan
- Reset, then a read at 0x4123 with `mem_ack` after 5 cycles and `mem_rdata`=8'hA5 → `mem_addr`=21'h00123, `mwait` low for the whole request, bus shows 8'hA5, `mdata_oe` drops after `mrd` rises.
- Write 8'h07 to 0x7000, then read 0x8001 → no `mem_req` for the write; the read has `mem_addr`={8'h07, 13'h0001}.
- Write 8'h3C to 0x9000 → `mem_req` with `mem_we`=1, `mem_wdata`=8'h3C, `mwait` released on ack.
- Read with `mem_ack` withheld → `mwait` released after 63 cycles, bus shows 8'hFF, `timeout`=1, a late ack is ignored.
- Read at 0xC000, and a cycle with `mrd`=`mwr`=0 → no `mem_req`, `mwait` stays 1, `mdata_oe` stays 0.
- With `MSX_IO_PORT_EN`: OUT (0x40),8'h5A then IN (0x40) → reads 8'h5A with `mbusdir`=0; the same cycle with `mm1`=0 → ignored.
